// File: rtl/branch_unit_pkg.sv
// Shared constants for the branch unit: instruction phases, branch opcodes,
// condition codes and flag bit positions within the {S,Z,C,V} flag word.
package branch_unit_pkg;

    // Instruction phases
    localparam logic [2:0] PH_FETCH = 3'b000;
    localparam logic [2:0] PH_DEC   = 3'b001;
    localparam logic [2:0] PH_EX    = 3'b010;
    localparam logic [2:0] PH_MEM   = 3'b011;
    localparam logic [2:0] PH_WB    = 3'b100;

    // Branch opcodes, instr[15:11]
    localparam logic [4:0] OP_B   = 5'b10100;
    localparam logic [4:0] OP_BCC = 5'b10111;

    // Condition codes, instr[10:8]; 100..111 are never taken
    localparam logic [2:0] CC_BE  = 3'b000;
    localparam logic [2:0] CC_BLT = 3'b001;
    localparam logic [2:0] CC_BLE = 3'b010;
    localparam logic [2:0] CC_BNE = 3'b011;

    // Flag bit indices in flags_out
    localparam int unsigned FLAG_S = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch decoder.
// Ports:
//   instr_hi  - instruction bits [15:8] (opcode + condition field)
//   flags     - architectural flags {S,Z,C,V}
//   is_branch - instruction is B or Bcc
//   taken     - branch is taken under the given flags
module branch_cond
    import branch_unit_pkg::*;
(
    input  logic [7:0] instr_hi,
    input  logic [3:0] flags,
    output logic       is_branch,
    output logic       taken
);

    logic [4:0] opcode;
    logic [2:0] cond;
    logic       lt;
    logic       cond_true;

    assign opcode = instr_hi[7:3];
    assign cond   = instr_hi[2:0];
    assign lt     = flags[FLAG_S] ^ flags[FLAG_V];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            CC_BE:   cond_true = flags[FLAG_Z];
            CC_BLT:  cond_true = lt;
            CC_BLE:  cond_true = flags[FLAG_Z] | lt;
            CC_BNE:  cond_true = ~flags[FLAG_Z];
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        if (opcode == OP_B) begin
            is_branch = 1'b1;
            taken     = 1'b1;
        end else if (opcode == OP_BCC) begin
            is_branch = 1'b1;
            taken     = cond_true;
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: holds the condition flags, decodes branches and produces the
// registered jump request consumed by the program counter in phase 100.
// Ports:
//   clock, rst     - rising-edge clock, asynchronous active-low reset
//   phase          - instruction phase 000..100 (101..111 hold everything)
//   pc_in          - current PC
//   instr          - instruction register
//   alu_s/z/c/v    - ALU flag results; flag_we enables the phase-010 update
//   j_flag, j_addr - jump request and base address (PC adds the final +1)
//   flags_out      - {S,Z,C,V}
//   taken_cnt      - saturating count of taken branches
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned DW = 8
) (
    input  logic         clock,
    input  logic         rst,
    input  logic [2:0]   phase,
    input  logic [W-1:0] pc_in,
    input  logic [W-1:0] instr,
    input  logic         alu_s,
    input  logic         alu_z,
    input  logic         alu_c,
    input  logic         alu_v,
    input  logic         flag_we,
    output logic         j_flag,
    output logic [W-1:0] j_addr,
    output logic [3:0]   flags_out,
    output logic [W-1:0] taken_cnt
);

    localparam logic [W-1:0] CntMax = '1;

    logic [3:0]   flags_q, flags_d;
    logic         j_flag_q, j_flag_d;
    logic [W-1:0] j_addr_q, j_addr_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         is_branch;
    logic         taken;
    logic [W-1:0] disp;

    // Condition is evaluated on the registered flags, so a phase-010 update
    // is already visible at the phase-011 decision edge.
    branch_cond u_branch_cond (
        .instr_hi  (instr[15:8]),
        .flags     (flags_q),
        .is_branch (is_branch),
        .taken     (taken)
    );

    assign disp = {{(W-DW){instr[DW-1]}}, instr[DW-1:0]};

    always_comb begin
        flags_d  = flags_q;
        j_flag_d = j_flag_q;
        j_addr_d = j_addr_q;
        cnt_d    = cnt_q;
        case (phase)
            PH_EX: begin
                if (flag_we) begin
                    flags_d = {alu_s, alu_z, alu_c, alu_v};
                end
            end
            PH_MEM: begin
                j_flag_d = taken;
                j_addr_d = pc_in + disp;
                if (taken && (cnt_q != CntMax)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PH_WB: begin
                j_flag_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            flags_q  <= 4'b0000;
            j_flag_q <= 1'b0;
            j_addr_q <= '0;
            cnt_q    <= '0;
        end else begin
            flags_q  <= flags_d;
            j_flag_q <= j_flag_d;
            j_addr_q <= j_addr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign j_flag    = j_flag_q;
    assign j_addr    = j_addr_q;
    assign flags_out = flags_q;
    assign taken_cnt = cnt_q;

    // is_branch is informational; taken already implies a branch.
    logic unused_is_branch;
    assign unused_is_branch = is_branch;

endmodule
